// File: rtl/bcd_to_seven_segment.sv
// bcd_to_seven_segment: registered BCD to seven-segment decoder.
//
// Segment bit order is {a,b,c,d,e,f,g} = segment[6:0]. Every output is
// registered, so the latency from the inputs is exactly one clock and
// there is no combinational path from any input to any output.
//
// Priority, highest first: rst, lamp_test (all lit), blank (all dark),
// then the decode itself. BCD codes 10..15 display dark and raise invalid.
// invalid always follows the sampled bcd value, whatever blank and
// lamp_test are doing.
//
// Parameter ACTIVE_LOW inverts every segment/dp output, including the
// reset value, for common-anode displays.
//
// Optional decimal point: define BCD_TO_SEVEN_SEGMENT_DP_EN to add the
// dp_in input and the dp output. dp follows the same priority rules and
// resets dark.

module bcd_to_seven_segment #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       lamp_test,
`ifdef BCD_TO_SEVEN_SEGMENT_DP_EN
  input  logic       dp_in,
  output logic       dp,
`endif
  output logic [6:0] segment,
  output logic       invalid
);

  // XOR mask that turns an active-high pattern into the output polarity.
  // It is also the "all dark" value at the output pins.
  localparam logic [6:0] SEG_POL_MASK = {7{ACTIVE_LOW}};

  logic [6:0] decode_pat;   // active-high pattern for the bcd digit
  logic [6:0] segment_d;
  logic [6:0] segment_q;
  logic       invalid_d;
  logic       invalid_q;

  // Digit decode, active-high, abcdefg.
  // NOTE: the default arm assigns every non-decimal code, so no latch is inferred and no X escapes.
  always_comb begin
    case (bcd)
      4'd0:    decode_pat = 7'b1111110;
      4'd1:    decode_pat = 7'b0110000;
      4'd2:    decode_pat = 7'b1101101;
      4'd3:    decode_pat = 7'b1111001;
      4'd4:    decode_pat = 7'b0110011;
      4'd5:    decode_pat = 7'b1011011;
      4'd6:    decode_pat = 7'b1011111;
      4'd7:    decode_pat = 7'b1110000;
      4'd8:    decode_pat = 7'b1111111;
      4'd9:    decode_pat = 7'b1111011;
      default: decode_pat = 7'b0000000;
    endcase
  end

  // Apply lamp_test/blank overrides and the output polarity.
  always_comb begin
    invalid_d = (bcd > 4'd9);
    segment_d = decode_pat;
    if (lamp_test) begin
      segment_d = 7'b1111111;
    end else if (blank) begin
      segment_d = 7'b0000000;
    end
    segment_d = segment_d ^ SEG_POL_MASK;
  end

  // Output registers with synchronous reset to the dark pattern.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      segment_q <= SEG_POL_MASK;
      invalid_q <= 1'b0;
    end else begin
      segment_q <= segment_d;
      invalid_q <= invalid_d;
    end
  end

  assign segment = segment_q;
  assign invalid = invalid_q;

`ifdef BCD_TO_SEVEN_SEGMENT_DP_EN
  logic dp_d;
  logic dp_q;

  // Decimal point follows the same lamp_test/blank priority and polarity.
  always_comb begin
    dp_d = dp_in;
    if (lamp_test) begin
      dp_d = 1'b1;
    end else if (blank) begin
      dp_d = 1'b0;
    end
    dp_d = dp_d ^ ACTIVE_LOW;
  end

  // Decimal point register, resets dark.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_q <= ACTIVE_LOW;
    end else begin
      dp_q <= dp_d;
    end
  end

  assign dp = dp_q;
`endif

endmodule

// File: tb/tb_bcd_to_seven_segment.sv
// tb_bcd_to_seven_segment: directed self-checking bench.
// Two instances share all inputs: u_dut (active-high outputs) and
// u_dut_al (ACTIVE_LOW=1). Inputs change after the rising edge; outputs
// are sampled 1 ns after the next rising edge.

module tb_bcd_to_seven_segment;

  logic       clk;
  logic       rst;
  logic [3:0] bcd;
  logic       blank;
  logic       lamp_test;
  logic [6:0] segment;
  logic       invalid;
  logic [6:0] segment_al;
  logic       invalid_al;
`ifdef BCD_TO_SEVEN_SEGMENT_DP_EN
  logic       dp_in;
  logic       dp;
  logic       dp_al;
`endif

  int checks;
  int errors;

  // Hand-written active-high patterns, abcdefg, for digits 0..9.
  logic [6:0] exp_table [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  bcd_to_seven_segment #(.ACTIVE_LOW(1'b0)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .bcd       (bcd),
    .blank     (blank),
    .lamp_test (lamp_test),
`ifdef BCD_TO_SEVEN_SEGMENT_DP_EN
    .dp_in     (dp_in),
    .dp        (dp),
`endif
    .segment   (segment),
    .invalid   (invalid)
  );

  bcd_to_seven_segment #(.ACTIVE_LOW(1'b1)) u_dut_al (
    .clk       (clk),
    .rst       (rst),
    .bcd       (bcd),
    .blank     (blank),
    .lamp_test (lamp_test),
`ifdef BCD_TO_SEVEN_SEGMENT_DP_EN
    .dp_in     (dp_in),
    .dp        (dp_al),
`endif
    .segment   (segment_al),
    .invalid   (invalid_al)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and move 1 ns past it for sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [6:0] exp_seg, input logic exp_inv);
    checks++;
    if (segment !== exp_seg) begin
      errors++;
      $display("FAIL %s segment: got %b expected %b", name, segment, exp_seg);
    end
    checks++;
    if (invalid !== exp_inv) begin
      errors++;
      $display("FAIL %s invalid: got %b expected %b", name, invalid, exp_inv);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bcd = 4'd8; lamp_test = 1'b1; blank = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      expect_out($sformatf("reset_edge%0d", i), 7'b0000000, 1'b0);
      checks++;
      if (segment_al !== 7'b1111111) begin
        errors++;
        $display("FAIL reset_al_edge%0d segment: got %b expected %b", i, segment_al, 7'b1111111);
      end
    end
    rst = 1'b0; lamp_test = 1'b0;
  endtask

  task automatic test_decode_sweep();
    for (int d = 0; d < 10; d++) begin
      bcd = 4'(d);
      step();
      expect_out($sformatf("decode_%0d", d), exp_table[d], 1'b0);
    end
  endtask

  task automatic test_invalid();
    bcd = 4'd10; step(); expect_out("invalid_10", 7'b0000000, 1'b1);
    bcd = 4'd15; step(); expect_out("invalid_15", 7'b0000000, 1'b1);
    bcd = 4'd3;  step(); expect_out("valid_3",    7'b1111001, 1'b0);
  endtask

  task automatic test_blank_lamp();
    bcd = 4'd5; blank = 1'b1; step(); expect_out("blank_5", 7'b0000000, 1'b0);
    lamp_test = 1'b1;         step(); expect_out("blank_lamp_5", 7'b1111111, 1'b0);
    bcd = 4'd12; blank = 1'b0; step(); expect_out("lamp_12", 7'b1111111, 1'b1);
    lamp_test = 1'b0;
    // Latency: output must still show the previous input right after a change.
    bcd = 4'd1;
    #1;
    checks++;
    if (segment !== 7'b1111111) begin
      errors++;
      $display("FAIL latency segment: got %b expected %b", segment, 7'b1111111);
    end
    step(); expect_out("after_lamp_1", 7'b0110000, 1'b0);
  endtask

  task automatic test_reset_mid();
    bcd = 4'd8; step(); expect_out("mid_pre", 7'b1111111, 1'b0);
    rst = 1'b1; bcd = 4'd14; lamp_test = 1'b1;
    step(); expect_out("mid_reset", 7'b0000000, 1'b0);
    rst = 1'b0; lamp_test = 1'b0; bcd = 4'd7;
    step(); expect_out("mid_resume", 7'b1110000, 1'b0);
  endtask

  task automatic test_active_low();
    bcd = 4'd1; step();
    checks++;
    if (segment_al !== 7'b1001111) begin
      errors++;
      $display("FAIL active_low_1 segment: got %b expected %b", segment_al, 7'b1001111);
    end
    checks++;
    if (invalid_al !== 1'b0) begin
      errors++;
      $display("FAIL active_low_1 invalid: got %b expected %b", invalid_al, 1'b0);
    end
    bcd = 4'd11; step();
    checks++;
    if (segment_al !== 7'b1111111 || invalid_al !== 1'b1) begin
      errors++;
      $display("FAIL active_low_11: got %b/%b expected %b/%b", segment_al, invalid_al, 7'b1111111, 1'b1);
    end
    rst = 1'b1; step();
    checks++;
    if (segment_al !== 7'b1111111) begin
      errors++;
      $display("FAIL active_low_reset segment: got %b expected %b", segment_al, 7'b1111111);
    end
    rst = 1'b0;
  endtask

`ifdef BCD_TO_SEVEN_SEGMENT_DP_EN
  task automatic test_dp();
    checks++;
    if (dp !== 1'b0 || dp_al !== 1'b1) begin
      errors++;
      $display("FAIL dp_reset: got %b/%b expected %b/%b", dp, dp_al, 1'b0, 1'b1);
    end
    dp_in = 1'b1; bcd = 4'd2; step();
    expect_out("dp_digit_2", 7'b1101101, 1'b0);
    checks++;
    if (dp !== 1'b1 || dp_al !== 1'b0) begin
      errors++;
      $display("FAIL dp_on: got %b/%b expected %b/%b", dp, dp_al, 1'b1, 1'b0);
    end
    blank = 1'b1; step();
    checks++;
    if (dp !== 1'b0) begin
      errors++;
      $display("FAIL dp_blank: got %b expected %b", dp, 1'b0);
    end
    dp_in = 1'b0; lamp_test = 1'b1; step();
    checks++;
    if (dp !== 1'b1) begin
      errors++;
      $display("FAIL dp_lamp: got %b expected %b", dp, 1'b1);
    end
    blank = 1'b0; lamp_test = 1'b0; step();
    checks++;
    if (dp !== 1'b0) begin
      errors++;
      $display("FAIL dp_off: got %b expected %b", dp, 1'b0);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; bcd = 4'd0; blank = 1'b0; lamp_test = 1'b0;
`ifdef BCD_TO_SEVEN_SEGMENT_DP_EN
    dp_in = 1'b0;
`endif
    #2;
    test_reset();
    test_decode_sweep();
    test_invalid();
    test_blank_lamp();
    test_reset_mid();
    test_active_low();
`ifdef BCD_TO_SEVEN_SEGMENT_DP_EN
    test_dp();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
